// File: rtl/cpu_mult_cell_pipe.sv
// cpu_mult_cell_pipe: pipelined split-half multiplier with stall, flush and signed-mode correction
module cpu_mult_cell_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     E_src1,
  input  logic [DATA_W-1:0]     E_src2,
  input  logic                  E_sign1,
  input  logic                  E_sign2,
  input  logic                  E_valid,
  input  logic                  M_en,
  input  logic                  M_flush,
  output logic [DATA_W-1:0]     M_mul_cell_p1,
  output logic [DATA_W-1:0]     M_mul_cell_p2,
  output logic [DATA_W-1:0]     M_mul_cell_p3,
  output logic [DATA_W-1:0]     M_mul_cell_p4,
  output logic [2*DATA_W-1:0]   M_mul_prod,
  output logic                  M_mul_valid,
  output logic                  M_mul_busy
);
  localparam int H  = DATA_W / 2;
  localparam int W2 = 2 * DATA_W;
  typedef struct packed {
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] p4;
    logic [DATA_W-1:0] p3;
    logic [DATA_W-1:0] p2;
    logic [DATA_W-1:0] p1;
  } stg_t;
  logic [LATENCY-1:0] v;
  stg_t [LATENCY-2:0] sd;
  stg_t nx;
  logic [W2-1:0] mid, prod_nx;
  // Half products of the issuing operands plus the sign-extension correction term
  always_comb begin
    nx.p1 = {{H{1'b0}}, E_src1[H-1:0]} * {{H{1'b0}}, E_src2[H-1:0]};
    nx.p2 = {{H{1'b0}}, E_src1[H-1:0]} * {{H{1'b0}}, E_src2[DATA_W-1:H]};
    nx.p3 = {{H{1'b0}}, E_src1[DATA_W-1:H]} * {{H{1'b0}}, E_src2[H-1:0]};
    nx.p4 = {{H{1'b0}}, E_src1[DATA_W-1:H]} * {{H{1'b0}}, E_src2[DATA_W-1:H]};
    nx.c  = ((E_sign1 & E_src1[DATA_W-1]) ? E_src2 : '0) + ((E_sign2 & E_src2[DATA_W-1]) ? E_src1 : '0);
  end
  // Recombine the half products; a negative operand contributes minus the other operand at weight 2^DATA_W
  always_comb begin
    mid     = W2'(sd[LATENCY-2].p2) + W2'(sd[LATENCY-2].p3);
    prod_nx = {sd[LATENCY-2].p4, sd[LATENCY-2].p1} + (mid << H) - {sd[LATENCY-2].c, {DATA_W{1'b0}}};
  end
  // Advance valid bits on enable, load data only behind a live op, flush kills valids, reset clears all
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v             <= '0;
      sd            <= '0;
      M_mul_prod    <= '0;
      M_mul_cell_p1 <= '0;
      M_mul_cell_p2 <= '0;
      M_mul_cell_p3 <= '0;
      M_mul_cell_p4 <= '0;
    end else begin
      if (M_en) begin
        v <= {v[LATENCY-2:0], E_valid};
        if (E_valid) sd[0] <= nx;
        for (int k = 1; k < LATENCY - 1; k++) if (v[k-1]) sd[k] <= sd[k-1];
        if (v[LATENCY-2]) begin
          M_mul_prod    <= prod_nx;
          M_mul_cell_p1 <= sd[LATENCY-2].p1;
          M_mul_cell_p2 <= sd[LATENCY-2].p2;
          M_mul_cell_p3 <= sd[LATENCY-2].p3;
          M_mul_cell_p4 <= sd[LATENCY-2].p4;
        end
      end
      if (M_flush) v <= '0;
    end
  end
  assign M_mul_valid = v[LATENCY-1];
  assign M_mul_busy  = |v;
endmodule
